z_run_logger: RTL and testbench

- Downstream consumer of the 1-bit `z` flag produced by the sequence-detect FSM.
- Measures each maximal run of consecutive `z`=1 cycles and records its length.
- Queues the records in a small FIFO and presents them to a sink through a valid/ready handshake.
- Tracks overflow and dropped records so software-facing logic can see lost data.

---
 rtl/z_run_logger.sv | 122 ++++++++++++
 tb/tb_z_run_logger.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/z_run_logger.sv
// Measures runs of consecutive z=1 cycles and queues {sat, len} records in a
// small FIFO drained through a valid/ready handshake; drops are counted.
module z_run_logger #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_RUN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     z,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W-1:0]         rec_len,
  output logic                     rec_sat,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     in_run,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;
  logic [CNT_W:0]   mem_q [DEPTH];

  logic push, pop, full, wr_en;
  logic [CNT_W:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign pop   = (count_q != '0) && rec_ready;
  // End-of-run edge carries the finished run's len/sat straight into the FIFO.
  assign push  = (state_q == RUN) && !z && (32'(len_q) >= MIN_RUN);
  assign wr_en = push && (!full || pop) && !reset;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sat_d      = sat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    case (state_q)
      IDLE: begin
        if (z) begin
          state_d = RUN;
          len_d   = CNT_W'(1);
          sat_d   = 1'b0;
        end
      end
      RUN: begin
        if (z) begin
          if (len_q != '1) len_d = len_q + CNT_W'(1);
          else             sat_d = 1'b1;
        end else begin
          state_d = IDLE;
          len_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);

    if (push && full && !pop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      sat_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sat_q      <= sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {sat_q, len_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign rec_valid  = (count_q != '0);
  assign rec_len    = rec_valid ? head[CNT_W-1:0] : '0;
  assign rec_sat    = rec_valid ? head[CNT_W] : 1'b0;
  assign fifo_count = count_q;
  assign in_run     = (state_q == RUN);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_z_run_logger.sv
// Directed bench for z_run_logger: default instance plus a MIN_RUN=3 instance.
module tb_z_run_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, z, rec_ready;
  logic       rec_valid, rec_sat, in_run, overflow;
  logic [7:0] rec_len, drop_cnt;
  logic [2:0] fifo_count;

  logic       reset3, z3, rec_ready3;
  logic       rec_valid3, rec_sat3, in_run3, overflow3;
  logic [7:0] rec_len3, drop_cnt3;
  logic [2:0] fifo_count3;

  z_run_logger dut (
    .clk(clk), .reset(reset), .z(z),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_len(rec_len), .rec_sat(rec_sat), .fifo_count(fifo_count),
    .in_run(in_run), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  z_run_logger #(.CNT_W(8), .DEPTH(4), .MIN_RUN(3)) dut3 (
    .clk(clk), .reset(reset3), .z(z3),
    .rec_valid(rec_valid3), .rec_ready(rec_ready3),
    .rec_len(rec_len3), .rec_sat(rec_sat3), .fifo_count(fifo_count3),
    .in_run(in_run3), .overflow(overflow3), .drop_cnt(drop_cnt3)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned len);
    z = 1'b1;
    repeat (len) step();
    z = 1'b0;
    step();
  endtask

  task automatic pop_one();
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; z = 1'b0; rec_ready = 1'b0;
    reset3 = 1'b1; z3 = 1'b0; rec_ready3 = 1'b0;
    #1;
    step();
    reset = 1'b0; reset3 = 1'b0;

    chk("rst_valid", 32'(rec_valid), 0);
    chk("rst_len",   32'(rec_len), 0);
    chk("rst_sat",   32'(rec_sat), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_inrun", 32'(in_run), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_drop",  32'(drop_cnt), 0);

    // Single run of 3, basic handshake
    z = 1'b1;
    step();
    chk("r3_inrun", 32'(in_run), 1);
    chk("r3_novalid", 32'(rec_valid), 0);
    step(); step();
    z = 1'b0;
    step();
    chk("r3_valid", 32'(rec_valid), 1);
    chk("r3_len",   32'(rec_len), 3);
    chk("r3_sat",   32'(rec_sat), 0);
    chk("r3_count", 32'(fifo_count), 1);
    chk("r3_inrun_end", 32'(in_run), 0);
    step();
    chk("r3_hold_len", 32'(rec_len), 3);
    pop_one();
    chk("r3_pop_valid", 32'(rec_valid), 0);
    chk("r3_pop_len",   32'(rec_len), 0);
    chk("r3_pop_count", 32'(fifo_count), 0);

    // Saturation: 300-edge run
    z = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      chk("sat_inrun", 32'(in_run), 1);
    end
    z = 1'b0;
    step();
    chk("sat_len", 32'(rec_len), 255);
    chk("sat_sat", 32'(rec_sat), 1);
    pop_one();
    chk("sat_pop_sat", 32'(rec_sat), 0);

    // Overflow: runs 1..5, no pops
    for (int unsigned l = 1; l <= 5; l++) run(l);
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_drop",  32'(drop_cnt), 1);
    for (int unsigned k = 1; k <= 4; k++) begin
      chk("ovf_drain_valid", 32'(rec_valid), 1);
      chk("ovf_drain_len",   32'(rec_len), k);
      pop_one();
    end
    chk("ovf_empty", 32'(rec_valid), 0);

    // Full with simultaneous pop
    for (int unsigned l = 5; l <= 8; l++) run(l);
    chk("fp_full", 32'(fifo_count), 4);
    z = 1'b1;
    step(); step();
    z = 1'b0; rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("fp_count", 32'(fifo_count), 4);
    chk("fp_drop",  32'(drop_cnt), 1);
    for (int unsigned k = 0; k < 4; k++) begin
      logic [7:0] exp_len;
      exp_len = (k == 3) ? 8'd2 : 8'(6 + k);
      chk("fp_drain_len", 32'(rec_len), 32'(exp_len));
      pop_one();
    end
    chk("fp_empty", 32'(rec_valid), 0);

    // Drop counter saturation
    for (int i = 0; i < 4; i++) run(1);
    for (int i = 0; i < 260; i++) run(1);
    chk("dsat_drop",  32'(drop_cnt), 255);
    chk("dsat_ovf",   32'(overflow), 1);
    chk("dsat_count", 32'(fifo_count), 4);

    // Reset mid-run
    z = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_inrun", 32'(in_run), 0);
    chk("mr_count", 32'(fifo_count), 0);
    chk("mr_ovf",   32'(overflow), 0);
    chk("mr_drop",  32'(drop_cnt), 0);
    step(); step();
    z = 1'b0;
    step();
    chk("mr_len",   32'(rec_len), 2);
    chk("mr_one",   32'(fifo_count), 1);
    step(); step();
    chk("mr_still_one", 32'(fifo_count), 1);
    chk("mr_ovf2",  32'(overflow), 0);
    chk("mr_drop2", 32'(drop_cnt), 0);

    // MIN_RUN=3 instance
    z3 = 1'b1;
    repeat (2) step();
    z3 = 1'b0;
    step();
    chk("mn_short_count", 32'(fifo_count3), 0);
    chk("mn_short_valid", 32'(rec_valid3), 0);
    z3 = 1'b1;
    repeat (3) step();
    z3 = 1'b0;
    step();
    chk("mn_count", 32'(fifo_count3), 1);
    chk("mn_len",   32'(rec_len3), 3);
    chk("mn_drop",  32'(drop_cnt3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
